audio_framer: RTL

- Sample-stream framer that sits upstream of the windowing stage in the MFCC pipeline.
- Accepts raw PCM samples from the audio front end into a circular buffer.
- When a complete frame is buffered, it pulses frame_start_o and serves the frame one sample per read request. This is the responder side of the windowing stage's rd_en/valid read handshake.
- After each frame it advances the frame base by HOP_SIZE, giving overlapping frames.

---
 rtl/audio_framer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/audio_framer.sv
// ---------------------------------------------------------------------------
// audio_framer
//   Sample-stream framer ahead of the MFCC windowing stage. Raw PCM samples
//   go into a circular buffer. When FRAME_LEN samples are held past the frame
//   base, the block pulses frame_start_o and then returns the frame one sample
//   per rd_en_i cycle, with one cycle of latency. After each frame the base
//   moves on by HOP_SIZE, so consecutive frames overlap.
//
// Ports
//   clk             clock
//   rst_n           asynchronous active-low reset
//   sample_i        signed PCM input sample
//   sample_valid_i  sample_i is valid this cycle
//   rd_en_i         read request from the windowing stage
//   frame_sample_o  signed frame sample for the previous cycle's read
//   valid_o         frame_sample_o is valid (registered)
//   frame_start_o   one-cycle pulse when a frame is ready
//   busy_o          high from frame_start_o until the frame has been served
//   overflow_o      sticky; an input sample was dropped on a full buffer
// ---------------------------------------------------------------------------
module audio_framer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_LEN    = 306,
  parameter int HOP_SIZE     = 153,
  parameter int BUF_DEPTH    = 512,
  parameter int PTR_W        = $clog2(BUF_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                           sample_valid_i,
  input  logic                           rd_en_i,
  output logic signed [SAMPLE_WIDTH-1:0] frame_sample_o,
  output logic                           valid_o,
  output logic                           frame_start_o,
  output logic                           busy_o,
  output logic                           overflow_o
);

  // The pointers carry one extra bit so that a full buffer (occ == BUF_DEPTH)
  // can be told apart from an empty one.
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] BUF_DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] HOP_C       = CNT_W'(HOP_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_ADVANCE
  } state_t;

  state_t state, state_nxt;

  logic [SAMPLE_WIDTH-1:0] mem [BUF_DEPTH];

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] base_nxt;
  logic [CNT_W-1:0] occ;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_idx_nxt;
  logic [PTR_W-1:0] rd_addr;

  logic wr_fire;
  logic wr_drop;
  logic rd_fire;
  logic frame_ready;
  logic frame_start_nxt;
  logic busy_nxt;

  // Modular subtraction at CNT_W bits gives the correct fill level across
  // pointer wrap-around. In the ADVANCE cycle this still uses the old base,
  // so space freed by the advance only becomes usable one cycle later.
  assign occ         = wr_ptr - base;
  assign frame_ready = (occ >= FRAME_LEN_C);
  assign wr_fire     = sample_valid_i && (occ < BUF_DEPTH_C);
  assign wr_drop     = sample_valid_i && (occ >= BUF_DEPTH_C);
  assign rd_fire     = (state == S_SERVE) && rd_en_i && (rd_idx < LAST_IDX);
  assign rd_addr     = base[PTR_W-1:0] + PTR_W'(rd_idx);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so that every flop samples
  // values from before the edge, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned (no inferred latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (frame_ready) state_nxt = S_SERVE;
      // By the time rd_idx reads FRAME_LEN, the final valid_o is already on
      // the output for this cycle.
      S_SERVE:   if (rd_idx == LAST_IDX) state_nxt = S_ADVANCE;
      S_ADVANCE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    frame_start_nxt = 1'b0;
    busy_nxt        = busy_o;
    rd_idx_nxt      = rd_idx;
    base_nxt        = base;
    unique case (state)
      S_IDLE: begin
        if (frame_ready) begin
          frame_start_nxt = 1'b1;
          busy_nxt        = 1'b1;
          rd_idx_nxt      = '0;
        end
      end
      S_SERVE: begin
        if (rd_fire) rd_idx_nxt = rd_idx + IDX_W'(1);
      end
      S_ADVANCE: begin
        base_nxt = base + HOP_C;
        busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered control, pointers and outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      base           <= '0;
      rd_idx         <= '0;
      frame_start_o  <= 1'b0;
      busy_o         <= 1'b0;
      valid_o        <= 1'b0;
      overflow_o     <= 1'b0;
      frame_sample_o <= '0;
    end else begin
      base          <= base_nxt;
      rd_idx        <= rd_idx_nxt;
      frame_start_o <= frame_start_nxt;
      busy_o        <= busy_nxt;
      valid_o       <= rd_fire;
      if (wr_fire) wr_ptr <= wr_ptr + CNT_W'(1);
      if (wr_drop) overflow_o <= 1'b1;
      // The frame region lies entirely below wr_ptr, so this read address
      // never collides with the address being written in the same cycle.
      if (rd_fire) frame_sample_o <= mem[rd_addr];
    end
  end

  // -------------------------------------------------------------------------
  // Sample buffer write port
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Its contents are only ever read
  // after they have been written, and leaving out the reset lets it map
  // onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[PTR_W-1:0]] <= sample_i;
  end

endmodule
